// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, constants and column priority helper for the keypad scanner
package keypad_pkg;
    localparam int KEY_W = 4;
    localparam logic [3:0] ROW_RESET = 4'b1110;
    localparam logic [3:0] COL_IDLE = 4'hF;
    typedef enum logic [1:0] {SCAN, CONFIRM, HOLD, RELEASE} state_t;
    function automatic logic [1:0] low_col(input logic [3:0] c);
        return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: one-cycle tick on the last cycle of every SCAN_CNTMAX+1 clk cycles
module scan_tick_gen #(
    parameter int SCAN_CNTMAX = 49999
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(SCAN_CNTMAX + 2);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(SCAN_CNTMAX);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with debounce and valid/ready output; KEY_REPEAT_EN adds auto-repeat
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_CNTMAX = 49999,
    parameter int DEB_CNT = 20,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       col,
    output logic [3:0]       row,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_down,
    output logic             overrun
);
    localparam int DW = $clog2(DEB_CNT + 2);
    if (DEB_CNT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) $error("keypad_scan_ctrl: counts must be >= 1");
    state_t state;
    logic [1:0] row_idx;
    logic [3:0] lat_col;
    logic [DW-1:0] deb_cnt;
    logic tick, idle, match, acc_hit, ev;
    logic [KEY_W-1:0] code;
    scan_tick_gen #(.SCAN_CNTMAX(SCAN_CNTMAX)) u_tick (.clk(clk), .rst(rst), .tick(tick));
    assign idle = col == COL_IDLE;
    assign match = col == lat_col;
    assign code = {row_idx, low_col(lat_col)};
    assign acc_hit = tick && state == CONFIRM && match && deb_cnt + 1'b1 == DW'(DEB_CNT);
    assign row = ~(~ROW_RESET << row_idx);
    assign key_down = state == HOLD || state == RELEASE;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= SCAN;
            row_idx <= '0;
            lat_col <= COL_IDLE;
            deb_cnt <= '0;
        end else if (tick) begin
            case (state)
                SCAN:
                    if (idle) row_idx <= row_idx + 1'b1;
                    else begin
                        lat_col <= col;
                        deb_cnt <= '0;
                        state <= CONFIRM;
                    end
                CONFIRM:
                    if (!match) begin
                        row_idx <= row_idx + 1'b1;
                        deb_cnt <= '0;
                        state <= SCAN;
                    end else if (acc_hit) begin
                        deb_cnt <= '0;
                        state <= HOLD;
                    end else deb_cnt <= deb_cnt + 1'b1;
                HOLD:
                    if (idle) begin
                        deb_cnt <= DW'(1);
                        state <= RELEASE;
                    end
                RELEASE:
                    if (!idle) begin
                        deb_cnt <= '0;
                        state <= HOLD;
                    end else if (deb_cnt + 1'b1 >= DW'(DEB_CNT)) begin
                        row_idx <= row_idx + 1'b1;
                        deb_cnt <= '0;
                        state <= SCAN;
                    end else deb_cnt <= deb_cnt + 1'b1;
                default: state <= SCAN;
            endcase
        end
`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2((REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER) + 1);
    logic [RW-1:0] rep_cnt;
    logic rep_run, rep_hit;
    // first repeat waits REPEAT_DLY ticks, later ones REPEAT_PER
    assign rep_hit = tick && state == HOLD && !idle &&
                     rep_cnt + 1'b1 == (rep_run ? RW'(REPEAT_PER) : RW'(REPEAT_DLY));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rep_cnt <= '0;
            rep_run <= 1'b0;
        end else if (tick) begin
            rep_cnt <= (state != HOLD || idle || rep_hit) ? '0 : rep_cnt + 1'b1;
            rep_run <= (state != HOLD || idle) ? 1'b0 : rep_run || rep_hit;
        end
    assign ev = acc_hit || rep_hit;
`else
    assign ev = acc_hit;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            key_code <= '0;
            key_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (ev && key_valid && !key_ready) overrun <= 1'b1;
        else if (ev) begin
            key_code <= code;
            key_valid <= 1'b1;
        end else if (key_valid && key_ready) key_valid <= 1'b0;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: vector tables, corner sequences and a randomized physical-keypad model
module tb_keypad_scan_ctrl;
    logic clk = 0, rst = 1;
    logic [3:0] col, row, key_code, col_drv = 4'hF, ppat = 4'hF, model_col;
    logic key_valid, key_ready, key_down, overrun;
    logic use_model = 0, rand_mode = 0, man_ready = 1, rnd_ready = 0, mon_en = 0;
    int prow = -1, cyc, n_chk = 0, n_fail = 0, n_hs = 0;
    logic [3:0] exp_q[$];

    keypad_scan_ctrl #(.SCAN_CNTMAX(3), .DEB_CNT(2), .REPEAT_DLY(4), .REPEAT_PER(2)) dut (
        .clk(clk), .rst(rst), .col(col), .row(row), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_down(key_down), .overrun(overrun));

    always #5 clk = ~clk;
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;
    always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));
    assign key_ready = rand_mode ? rnd_ready : man_ready;

    function automatic logic [3:0] row_of(input int r);
        return ~(4'b0001 << r);
    endfunction

    // physical keypad: the held key pulls its column low only while its row is driven
    always_comb model_col = (prow >= 0 && row == row_of(prow)) ? ppat : 4'hF;
    assign col = use_model ? model_col : col_drv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk)
        if (mon_en && key_valid && key_ready) begin
            n_hs++;
            chk("rand_event_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("rand_code", key_code, exp_q.pop_front());
        end

    task automatic do_reset();
        rst = 1; prow = -1; use_model = 0; col_drv = 4'hF; man_ready = 1; rand_mode = 0;
        @(posedge clk); #1; rst = 0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do begin @(posedge clk); #1; end while (cyc % 4 != 0);
        end
    endtask

    task automatic wait_down(input logic lvl, input string nm);
        int t = 0;
        while (key_down !== lvl && t < 200) begin @(posedge clk); #1; t++; end
        chk(nm, key_down, lvl);
    endtask

    task automatic wait_valid(input string nm);
        int t = 0;
        while (key_valid !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
        chk(nm, key_valid, 1);
    endtask

    typedef struct {logic [3:0] col; logic [3:0] row; logic valid;} idle_t;
    typedef struct {int r; logic [3:0] pat; logic [3:0] code;} press_t;
    idle_t iv[9];
    press_t pv[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 9; k++) iv[k] = '{4'hF, row_of(k % 4), 1'b0};
        pv[0] = '{1, 4'b1011, 4'd6};
        pv[1] = '{0, 4'b1100, 4'd0};
        pv[2] = '{3, 4'b0111, 4'd15};
        pv[3] = '{2, 4'b0101, 4'd9};
        pv[4] = '{3, 4'b1110, 4'd12};

        rst = 1; #3;
        chk("rst_row", row, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_down", key_down, 0);
        chk("rst_overrun", overrun, 0);
        do_reset();

        for (int k = 0; k < 9; k++) begin
            col_drv = iv[k].col;
            if (k > 0) wait_ticks(1);
            chk($sformatf("idle_row%0d", k), row, iv[k].row);
            chk($sformatf("idle_valid%0d", k), key_valid, iv[k].valid);
        end

        do_reset();
        wait_ticks(1);
        col_drv = 4'b1011;
        wait_ticks(2);
        chk("k6_early", key_valid, 0);
        wait_ticks(1);
        chk("k6_valid", key_valid, 1);
        chk("k6_code", key_code, 6);
        chk("k6_down", key_down, 1);
        @(posedge clk); #1;
        chk("k6_consumed", key_valid, 0);
        col_drv = 4'hF;
        wait_ticks(1);
        chk("k6_rel1_down", key_down, 1);
        wait_ticks(1);
        chk("k6_rel2_down", key_down, 0);
        chk("k6_resume_row", row, 4'b1011);
        chk("k6_single", key_valid, 0);

        do_reset();
        wait_ticks(1);
        col_drv = 4'b1110;
        wait_ticks(1);
        col_drv = 4'hF;
        wait_ticks(1);
        chk("bounce_row", row, 4'b1011);
        chk("bounce_valid", key_valid, 0);
        wait_ticks(1);
        chk("bounce_row2", row, 4'b0111);
        chk("bounce_down", key_down, 0);
        chk("bounce_overrun", overrun, 0);

        do_reset();
        use_model = 1;
        for (int i = 0; i < 5; i++) begin
            prow = pv[i].r; ppat = pv[i].pat;
            wait_valid($sformatf("tab%0d_valid", i));
            chk($sformatf("tab%0d_code", i), key_code, pv[i].code);
            chk($sformatf("tab%0d_down", i), key_down, 1);
            @(posedge clk); #1;
            chk($sformatf("tab%0d_consumed", i), key_valid, 0);
            wait_ticks(1);
            chk($sformatf("tab%0d_frozen", i), row, row_of(pv[i].r));
            prow = -1;
            wait_ticks(1);
            chk($sformatf("tab%0d_rel1", i), key_down, 1);
            wait_ticks(1);
            chk($sformatf("tab%0d_rel2", i), key_down, 0);
            chk($sformatf("tab%0d_next_row", i), row, row_of((pv[i].r + 1) % 4));
            chk($sformatf("tab%0d_no_extra", i), key_valid, 0);
        end
        chk("tab_overrun", overrun, 0);

        do_reset();
        man_ready = 0;
        col_drv = 4'b1110;
        wait_ticks(3);
        chk("repl_first_valid", key_valid, 1);
        chk("repl_first_code", key_code, 0);
        col_drv = 4'hF;
        wait_ticks(2);
        col_drv = 4'b1101;
        wait_ticks(2);
        repeat (3) begin @(posedge clk); #1; end
        man_ready = 1;
        @(posedge clk); #1;
        chk("repl_valid", key_valid, 1);
        chk("repl_code", key_code, 5);
        chk("repl_overrun", overrun, 0);
        col_drv = 4'hF;

        do_reset();
        man_ready = 0; use_model = 1;
        prow = 0; ppat = 4'b1110;
        wait_down(1, "ovr_press0");
        prow = -1;
        wait_down(0, "ovr_release0");
        prow = 3; ppat = 4'b0111;
        wait_down(1, "ovr_press15");
        chk("ovr_code", key_code, 0);
        chk("ovr_valid", key_valid, 1);
        chk("ovr_flag", overrun, 1);
        man_ready = 1;
        @(posedge clk); #1;
        chk("ovr_cleared", key_valid, 0);
        chk("ovr_sticky", overrun, 1);
        prow = -1;
        wait_down(0, "ovr_release15");
        chk("ovr_sticky2", overrun, 1);

        do_reset();
        man_ready = 0; use_model = 1;
        prow = 2; ppat = 4'b1101;
        wait_down(1, "rh_press");
        chk("rh_code", key_code, 9);
        wait_ticks(1);
        @(posedge clk); #3;
        rst = 1; prow = -1;
        #1;
        chk("rh_row", row, 4'b1110);
        chk("rh_down", key_down, 0);
        chk("rh_valid", key_valid, 0);
        chk("rh_code0", key_code, 0);
        chk("rh_overrun", overrun, 0);

        do_reset();
        col_drv = 4'b1110;
        wait_ticks(3);
        chk("rep_accept", key_valid, 1);
        for (int k = 1; k <= 11; k++) begin
            logic e;
            e = 0;
`ifdef KEY_REPEAT_EN
            e = k >= 4 && k % 2 == 0;
`endif
            wait_ticks(1);
            chk($sformatf("rep_tick%0d", k), key_valid, e);
        end
        col_drv = 4'hF;
        wait_ticks(2);
        chk("rep_release", key_down, 0);
        chk("rep_overrun", overrun, 0);

        do_reset();
        use_model = 1; rand_mode = 1; mon_en = 1; n_hs = 0;
        for (int i = 0; i < 40; i++) begin
            int r, c;
            logic [3:0] hi, pat;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            hi = 4'($urandom);
            pat = (hi | 4'((1 << c) - 1)) & ~4'(1 << c);
            exp_q.push_back(4'(r * 4 + c));
            prow = r; ppat = pat;
            wait_down(1, "rand_press");
            wait_ticks($urandom_range(0, 2));
            prow = -1;
            wait_down(0, "rand_release");
            wait_ticks(1);
        end
        repeat (50) @(posedge clk);
        #1;
        mon_en = 0;
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_event_count", n_hs, 40);
        chk("rand_overrun", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_CNTMAX, default 49999, giving the row dwell as SCAN_CNTMAX+1 clk cycles (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEB_CNT, default 20, giving the consecutive matching samples required to accept a press or a release.
REQ-003 SHALL have parameter REPEAT_DLY, default 500, giving the dwell periods from acceptance to the first auto-repeat.
REQ-004 SHALL have parameter REPEAT_PER, default 100, giving the dwell periods between later auto-repeats.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port col, input, 4 bits: keypad columns, active-low, pulled up externally.
REQ-008 SHALL have port row, output, 4 bits: keypad row drive, one-cold (one row low at a time).
REQ-009 SHALL have port key_code, output, 4 bits: accepted key code, equal to row_index*4 + col_index.
REQ-010 SHALL have port key_valid, output, 1 bit: asserted while an accepted key code is pending.
REQ-011 SHALL have port key_ready, input, 1 bit: consumer accepts the pending code.
REQ-012 SHALL have port key_down, output, 1 bit: level, high while a debounced key is held.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, set when a key event is dropped.

Function
REQ-014 SHALL generate a dwell tick on the last cycle of every SCAN_CNTMAX+1-cycle period; col SHALL be sampled only on ticks.
REQ-015 SHALL implement the states SCAN, CONFIRM, HOLD and RELEASE.
REQ-016 SCAN: on a tick with col==4'hF, SHALL advance the driven row in the order 0,1,2,3,0 (wrap); on a tick with any col low, SHALL latch the row and the column pattern, then go to CONFIRM with the row unchanged.
REQ-017 CONFIRM: each tick whose pattern equals the latched pattern SHALL increment the match count; a different pattern or col==4'hF SHALL return to SCAN at the next row; when the count reaches DEB_CNT the key SHALL be accepted and the state SHALL go to HOLD.
REQ-018 When several columns are low together, the lowest column index SHALL determine the key code.
REQ-019 HOLD: key_down=1 and the row SHALL stay frozen; a tick with col==4'hF SHALL go to RELEASE.
REQ-020 RELEASE: DEB_CNT consecutive ticks with col==4'hF SHALL set key_down=0 and go to SCAN at the next row; any low column SHALL return to HOLD with no new event.
REQ-021 Acceptance SHALL load key_code and set key_valid on the following clk edge (latency 1 cycle after the deciding tick).
REQ-022 key_valid and key_code SHALL stay stable until a cycle with key_valid&&key_ready; key_valid SHALL clear on the next edge.
REQ-023 An event arriving while key_valid=1 and key_ready=0 SHALL be dropped and SHALL set overrun; if key_ready=1 in that same cycle, the new code SHALL replace the old one and key_valid SHALL stay 1 with no overrun.

Reset
REQ-024 While rst=1, asynchronously: row=4'b1110, state=SCAN, all counters=0, key_code=0, key_valid=0, key_down=0, overrun=0.
REQ-025 overrun SHALL clear only on reset; a reset mid-debounce or mid-hold SHALL discard the key with no event.

Configuration
REQ-026 With KEY_REPEAT_EN defined, HOLD SHALL emit a repeat event (same code, same rules as REQ-021..023) REPEAT_DLY ticks after acceptance and every REPEAT_PER ticks thereafter, and leaving HOLD SHALL reset the repeat counter.
REQ-027 Without KEY_REPEAT_EN, there SHALL be no repeat counter or logic, and exactly one event per press.

Structure
REQ-028 Package keypad_pkg SHALL hold the state enum, ROW_RESET=4'b1110, COL_IDLE=4'hF and KEY_W=4.
REQ-029 The dwell tick SHALL be produced by sub-module scan_tick_gen (parameter SCAN_CNTMAX, outputs tick).

Verification (SCAN_CNTMAX=3, DEB_CNT=2, REPEAT_DLY=4, REPEAT_PER=2)
REQ-030 Idle col=4'hF for 32 cycles -> row cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid=0.
REQ-031 Hold col=4'b1011 while row=1101 (row 1) for 3 ticks, key_ready=1 -> a single key_valid pulse with key_code=6; then col=4'hF for 2 ticks -> key_down falls, scan resumes at row 2.
REQ-032 col low for 1 tick only (bounce) -> return to SCAN, no key_valid, overrun=0.
REQ-033 key_ready=0; two separate presses of code 0 then code 15 -> key_code stays 0 and overrun=1; key_ready=1 -> key_valid clears next cycle.
REQ-034 col=4'b1100 on row 0 -> key_code=0 (lowest column wins); assert rst mid-HOLD -> all outputs return to reset values immediately.
REQ-035 KEY_REPEAT_EN defined, key held 12 ticks, key_ready=1 -> events at accept, accept+4, accept+6, accept+8 and accept+10 ticks; macro undefined -> one event.
